// File: rtl/baud_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package     : baud_pkg
// Description : Shared widths, reset divisor and types for the baud-rate
//               tick generator and its divisor down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package baud_pkg;

  // Divisor / down-counter width in bits
  localparam int DIV_W      = 16;
  // Receiver ticks per transmitter tick (power of two)
  localparam int OVERSAMPLE = 16;
  // Width of the oversample phase counter
  localparam int OS_W       = $clog2(OVERSAMPLE);
  // Width of one bus byte
  localparam int BYTE_W     = 8;

  typedef logic [DIV_W-1:0]  div_t;
  typedef logic [BYTE_W-1:0] byte_t;

  // 50 MHz / (16 * 19200) - 1, rounded
  localparam div_t RESET_DIV = 16'd162;

  // Assemble a divisor from its high and low bus bytes
  function automatic div_t join_div(input byte_t hi, input byte_t lo);
    return div_t'({hi, lo});
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_gen_if.sv
`default_nettype none
// ============================================================================
// Interface   : baud_gen_if
// Description : CPU-side divisor bus plus the tick outputs of the baud-rate
//               generator. The master side loads the divisor and consumes
//               the ticks; the slave side is the generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface baud_gen_if;
  import baud_pkg::*;

  logic  en;
  byte_t din;
  logic  wr_div_lo;
  logic  wr_div_hi;
  div_t  divisor;
  logic  baud_rate_generator;
  logic  tx_tick;

  modport master (
    output en,
    output din,
    output wr_div_lo,
    output wr_div_hi,
    input  divisor,
    input  baud_rate_generator,
    input  tx_tick
  );

  modport slave (
    input  en,
    input  din,
    input  wr_div_lo,
    input  wr_div_hi,
    output divisor,
    output baud_rate_generator,
    output tx_tick
  );

endinterface
`default_nettype wire

// File: rtl/baud_div_cnt.sv
`default_nettype none
// ============================================================================
// Module      : baud_div_cnt
// Description : Loadable down-counter with zero-detect tick. Counts down
//               once per enabled cycle; on reaching zero it reloads from
//               i_reload_val and raises o_tick for exactly the next cycle.
//               A load always wins over the tick decision of that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_div_cnt #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_hold,
  input  wire logic [WIDTH-1:0] i_reload_val,
  output logic                  o_fire,
  output logic                  o_tick
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_tick;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);

  // Edge that will produce a tick: counter empty, running, not being reloaded
  assign o_fire = w_zero & ~i_hold & ~i_load;

  // Down-count with reload on zero; hold and load suppress the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= RESET_VAL;
      r_tick <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_tick <= 1'b0;
    end else if (i_hold) begin
      r_tick <= 1'b0;
    end else if (w_zero) begin
      r_cnt  <= i_reload_val;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_gen
// Description : Programmable baud-rate tick generator. A 16-bit divisor is
//               loaded through two byte writes (low byte staged, high byte
//               commits). Emits a one-cycle oversample tick every divisor+1
//               cycles and a one-cycle bit tick on every OVERSAMPLE-th
//               oversample tick. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_gen
  import baud_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  reset,
  baud_gen_if.slave  bus
);

  localparam byte_t c_RESET_LO = RESET_DIV[BYTE_W-1:0];

  byte_t r_lo_stage;
  div_t  r_divisor;
  byte_t w_lo_byte;
  div_t  w_commit_val;
  logic  w_commit;
  logic  w_hold;
  logic  w_fire;
  logic  w_baud_tick;
  logic  w_tx_tick;

  // A same-cycle low write bypasses the stage so {din, din} is committed
  assign w_commit     = bus.wr_div_hi;
  assign w_hold       = ~bus.en;
  assign w_lo_byte    = bus.wr_div_lo ? bus.din : r_lo_stage;
  assign w_commit_val = join_div(bus.din, w_lo_byte);

  // Low-byte staging register; reset discards any partial write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo_stage <= c_RESET_LO;
    end else if (bus.wr_div_lo) begin
      r_lo_stage <= bus.din;
    end
  end

  // Committed divisor; writes are accepted regardless of en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_divisor <= RESET_DIV;
    end else if (w_commit) begin
      r_divisor <= w_commit_val;
    end
  end

  baud_div_cnt #(
    .WIDTH     (DIV_W),
    .RESET_VAL (RESET_DIV)
  ) u_div_cnt (
    .clk          (clk),
    .rst_n        (reset),
    .i_load       (w_commit),
    .i_load_val   (w_commit_val),
    .i_hold       (w_hold),
    .i_reload_val (r_divisor),
    .o_fire       (w_fire),
    .o_tick       (w_baud_tick)
  );

  generate
    if (OVERSAMPLE > 1) begin : g_os_div
      localparam logic [OS_W-1:0] c_OS_LAST = OS_W'(OVERSAMPLE - 1);

      logic [OS_W-1:0] r_os_cnt;
      logic            r_tx_tick;

      // Count oversample ticks; the last one of each group also fires tx_tick
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_os_cnt  <= '0;
          r_tx_tick <= 1'b0;
        end else if (w_commit) begin
          r_os_cnt  <= '0;
          r_tx_tick <= 1'b0;
        end else if (w_fire) begin
          if (r_os_cnt == c_OS_LAST) begin
            r_os_cnt  <= '0;
            r_tx_tick <= 1'b1;
          end else begin
            r_os_cnt  <= r_os_cnt + OS_W'(1);
            r_tx_tick <= 1'b0;
          end
        end else begin
          r_tx_tick <= 1'b0;
        end
      end

      assign w_tx_tick = r_tx_tick;
    end else begin : g_os_bypass
      // With no oversampling every receiver tick is also a bit tick
      assign w_tx_tick = w_baud_tick;
    end
  endgenerate

  assign bus.divisor             = r_divisor;
  assign bus.baud_rate_generator = w_baud_tick;
  assign bus.tx_tick             = w_tx_tick;

endmodule
`default_nettype wire

// File: tb/tb_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_baud_gen
// Description : Self-checking bench for baud_gen. The reference model counts
//               enabled edges since the last phase restart and derives the
//               expected ticks from divisibility by the tick periods.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baud_gen;
  import baud_pkg::*;

  logic clk;
  logic reset;

  baud_gen_if bus ();

  baud_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int    n_edges;   // enabled, non-commit edges since phase start
  int    d_model;   // committed divisor
  byte_t lo_model;  // staged low byte
  logic  exp_baud;
  logic  exp_tx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edges  = 0;
    d_model  = int'(RESET_DIV);
    lo_model = RESET_DIV[7:0];
    exp_baud = 1'b0;
    exp_tx   = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs
  task automatic step(input logic e, input byte_t d, input logic lo, input logic hi);
    bus.en        = e;
    bus.din       = d;
    bus.wr_div_lo = lo;
    bus.wr_div_hi = hi;
    @(posedge clk);
    if (hi) begin
      d_model  = {16'd0, d, (lo ? d : lo_model)};
      n_edges  = 0;
      exp_baud = 1'b0;
      exp_tx   = 1'b0;
    end else if (e) begin
      n_edges++;
      exp_baud = (n_edges % (d_model + 1)) == 0;
      exp_tx   = (n_edges % (OVERSAMPLE * (d_model + 1))) == 0;
    end else begin
      exp_baud = 1'b0;
      exp_tx   = 1'b0;
    end
    if (lo) lo_model = d;
    #1;
    check("baud_rate_generator", {31'd0, bus.baud_rate_generator}, {31'd0, exp_baud});
    check("tx_tick", {31'd0, bus.tx_tick}, {31'd0, exp_tx});
    check("divisor", {16'd0, bus.divisor}, d_model);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  // Async reset asserted between edges; outputs must clear at once
  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check({tag, "_baud"}, {31'd0, bus.baud_rate_generator}, 32'd0);
    check({tag, "_tx"}, {31'd0, bus.tx_tick}, 32'd0);
    check({tag, "_div"}, {16'd0, bus.divisor}, 32'd162);
    @(posedge clk);
    #1;
    check({tag, "_hold_baud"}, {31'd0, bus.baud_rate_generator}, 32'd0);
    #3 reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.en        = 1'b0;
    bus.din       = 8'h00;
    bus.wr_div_lo = 1'b0;
    bus.wr_div_hi = 1'b0;
    model_reset();

    // Power-on reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_baud", {31'd0, bus.baud_rate_generator}, 32'd0);
    check("rst_tx", {31'd0, bus.tx_tick}, 32'd0);
    check("rst_div", {16'd0, bus.divisor}, 32'd162);
    #3 reset = 1'b1;

    // Default divisor 162: pulses every 163 cycles, first tx_tick at 2608
    run(2700);

    // Two-byte load of divisor 3
    step(1'b1, 8'h03, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    check("div3_commit", {16'd0, bus.divisor}, 32'h0003);
    run(140);

    // Divisor 0: oversample tick every cycle
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    run(40);

    // Simultaneous low/high write commits {din, din}
    step(1'b1, 8'h01, 1'b1, 1'b1);
    check("same_cycle_div", {16'd0, bus.divisor}, 32'h0101);
    run(600);

    // Divisor 5 with an enable gap starting when the counter reaches 2
    step(1'b1, 8'h05, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    run(3);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    run(2);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("resume_pulse", {31'd0, bus.baud_rate_generator}, 32'd1);
    run(20);

    // Commit while disabled, then resume
    step(1'b0, 8'h02, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    run(60);

    // Divisor 3, stage a low byte, then reset right after a pulse
    step(1'b1, 8'h03, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    run(4);
    check("pre_reset_pulse", {31'd0, bus.baud_rate_generator}, 32'd1);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    async_reset_check("mid_reset");
    run(5);
    // Staged byte must have reverted to 0xA2
    step(1'b1, 8'h00, 1'b0, 1'b1);
    check("lo_stage_revert", {16'd0, bus.divisor}, 32'h00A2);
    run(200);

    // Randomized divisors, enable gaps and stray low-byte writes
    for (int p = 0; p < 6; p++) begin
      step(1'b1, 8'($urandom_range(0, 9)), 1'b1, 1'b0);
      step($urandom_range(0, 1) == 1, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 7) != 0, 8'($urandom), $urandom_range(0, 19) == 0, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/baud_gen.md
Name: baud_gen

Overview:
Programmable baud-rate tick generator that sits directly upstream of the UART receiver and drives its baud_rate_generator enable input. The CPU-side bus loads a 16-bit divisor through two byte writes. The block emits a 16x-oversample tick for the receiver and a 1x bit tick for the transmitter. All logic is in the single system clock domain.

Parameters:
DIV_W, 16, divisor and down-counter width in bits.
RESET_DIV, 16'd162, divisor loaded at reset (50 MHz / (16*19200) - 1, rounded).
OVERSAMPLE, 16, receiver ticks per transmitter tick; must be a power of two.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  active-low asynchronous reset (asserted when 0).
en  in  1  global enable; when 0, counters hold and ticks are suppressed.
din  in  8  divisor byte from the bus.
wr_div_lo  in  1  strobe: stage din as the divisor low byte.
wr_div_hi  in  1  strobe: commit {din, staged_lo} as the new divisor.
divisor  out  DIV_W  currently committed divisor.
baud_rate_generator  out  1  one-cycle oversample tick, connects to the receiver input of the same name.
tx_tick  out  1  one-cycle bit tick, coincident with every OVERSAMPLE-th baud_rate_generator pulse.

Behaviour:
- Reset (reset=0, async):
  - divisor=RESET_DIV; lo_stage=RESET_DIV[7:0]; cnt=RESET_DIV; os_cnt=0.
  - baud_rate_generator=0; tx_tick=0.
- Divisor load:
  - wr_div_lo: lo_stage<=din. divisor is unchanged.
  - wr_div_hi: divisor<=={din,lo_stage}; cnt<={din,lo_stage}; os_cnt<=0. Phase restarts on the committed value.
  - wr_div_lo and wr_div_hi in the same cycle: lo_stage<=din, divisor<={din,din}, cnt<={din,din}, os_cnt<=0.
  - A commit overrides any tick decision in that cycle. Both outputs are 0 in the following cycle.
- Counting (en=1, no commit):
  - cnt!=0: cnt<=cnt-1.
  - cnt==0 at an edge: cnt<=divisor and baud_rate_generator=1 for exactly the next cycle.
  - Tick period is divisor+1 cycles.
  - After reset release (or after a commit of D), the first tick is high after D+1 rising edges.
  - divisor==0: baud_rate_generator is high every cycle while en=1.
- Oversample divider:
  - os_cnt (log2(OVERSAMPLE) bits) increments on each edge that produces a baud_rate_generator pulse.
  - When os_cnt==OVERSAMPLE-1 at that edge, tx_tick is high in the same cycle as baud_rate_generator, and os_cnt wraps to 0.
  - tx_tick period is OVERSAMPLE*(divisor+1) cycles.
- en=0: cnt and os_cnt hold; both ticks are 0 the next cycle. When en returns to 1, counting resumes from the held cnt with no extra tick. Divisor writes are still accepted while en=0.
- Outputs are registered; no combinational path from any input to the ticks.
- Reset mid-count: immediate return to reset values. Any partially staged lo byte is discarded (reverts to RESET_DIV[7:0]).

Decomposition:
- Package baud_pkg:
  - DIV_W, OVERSAMPLE, RESET_DIV constants.
  - typedef logic [DIV_W-1:0] div_t.
  - localparam OS_W = $clog2(OVERSAMPLE).
- One sub-module, baud_div_cnt: a loadable down-counter with a zero-detect tick output, plus load and hold inputs.
  - baud_gen instantiates it for the divisor stage.
  - The OVERSAMPLE divider stays inline in baud_gen.

Test Plan:
- Reset release, en=1, default divisor 162 -> first baud_rate_generator pulse after 163 edges, then every 163 cycles; first tx_tick at pulse 16 (cycle 2608).
- wr_div_lo din=0x03, then wr_div_hi din=0x00 -> divisor=0x0003; pulses every 4 cycles, each 1 cycle wide; tx_tick every 64 cycles; os_cnt restarts at commit.
- Commit divisor 0x0000 -> baud_rate_generator constantly 1; tx_tick high 1 cycle in every 16.
- wr_div_lo and wr_div_hi same cycle, din=0x01 -> divisor=0x0101; pulse period 258.
- Divisor 5, en dropped for 7 cycles when cnt==2 -> no pulses during the gap; next pulse exactly 3 edges after en returns.
- Divisor 3, reset asserted mid-count (async, between edges) -> outputs 0 immediately; after release divisor=162 and lo_stage=0xA2.
